fetch_unit: RTL

Instruction fetch front end for the 5-stage RISC-V core. It owns the fetch PC, issues one read per cycle to a synchronous instruction memory with fixed one-cycle latency, and buffers returned words with their PCs in a small FIFO. It presents one instruction per cycle to the decode stage of `data_path`. Decode stalls apply backpressure through `deq`; branch and jump resolution discards all buffered and in-flight work through `redirect`.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_instr_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: word width, the
// canonical NOP and the default reset vector.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequential fetch address; wraps silently at the top of the address space.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_instr_fifo.sv
// Small circular buffer holding {instruction, pc} pairs between instruction
// memory and decode. Flush empties it in one edge and wins over push/pop.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head_data
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff, push_eff;

  assign pop_eff  = pop && (count_q != '0);
  // Upstream credit keeps push away from a full buffer; the guard only
  // protects stored entries if that contract is ever broken.
  assign push_eff = push && ((count_q != CNT_W'(DEPTH)) || pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one credit-checked
// read per cycle to a one-cycle-latency memory and buffers returned words.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            deq,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              head_valid;
  logic [2*XLEN-1:0] head_data;

  // Buffered plus in-flight work must fit; a same-cycle deq grants no credit.
  assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(pend_valid_q);
  assign imem_req    = !redirect && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (redirect) begin
      fetch_pc_d   = redirect_pc;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = imem_req;
      if (imem_req) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = pc_next(fetch_pc_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .push       (pend_valid_q && !redirect),
    .push_data  ({imem_rdata, pend_pc_q}),
    .pop        (deq),
    .flush      (redirect),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign instr_valid = head_valid;
  assign instr       = head_valid ? head_data[2*XLEN-1:XLEN] : NOP_INSTR;
  assign instr_pc    = head_valid ? head_data[XLEN-1:0]      : '0;

endmodule
